// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the UART debug controller.
// Holds the single-byte command codes, the acknowledge bytes returned to the
// host, and the controller state encoding.
package uart_dbg_pkg;

  // Host command bytes
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] CMD_DUMP = 8'h44;  // 'D'
  localparam logic [7:0] CMD_CLR  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'

  // Acknowledge bytes sent back to the host
  localparam logic [7:0] ACK_OK   = 8'h4B;  // 'K'
  localparam logic [7:0] ACK_ERR  = 8'h3F;  // '?'

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    DUMP_LOAD,
    DUMP_WAIT,
    ACK
  } state_t;

endpackage

// File: rtl/uart_dbg_ctrl_if.sv
// Signal bundle between the debug controller and its neighbours
// (UART receiver/transmitter, processor under debug, dump memory).
//   rx_done/rx_data   : receiver completion level and received byte
//   tx_done           : transmitter completion level
//   tx_start/tx_data  : transmit start pulse and byte to send
//   halted            : processor reached its halt instruction
//   dump_data         : byte at dump_addr (combinational)
//   dump_addr         : dump byte index
//   cpu_enable        : processor clock enable
//   cpu_reset         : one-cycle processor reset pulse
//   busy              : controller not idle
// master = controller side, slave = surrounding system side.
interface uart_dbg_ctrl_if #(
  parameter int ADDR_W = 4
) ();
  import uart_dbg_pkg::*;

  logic              rx_done;
  logic [7:0]        rx_data;
  logic              tx_done;
  logic              halted;
  logic [7:0]        dump_data;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [ADDR_W-1:0] dump_addr;
  logic              cpu_enable;
  logic              cpu_reset;
  logic              busy;

  modport master (
    input  rx_done, rx_data, tx_done, halted, dump_data,
    output tx_start, tx_data, dump_addr, cpu_enable, cpu_reset, busy
  );

  modport slave (
    output rx_done, rx_data, tx_done, halted, dump_data,
    input  tx_start, tx_data, dump_addr, cpu_enable, cpu_reset, busy
  );

endinterface

// File: rtl/uart_dbg_ctrl_rise_detect.sv
// Registered rising-edge detector.
// Ports:
//   clock  : clock
//   reset  : asynchronous active-high reset (clears the delayed copy)
//   level  : input level flag
//   pulse  : high in the cycle where level is high and was low last cycle
// A level held high produces a single pulse only.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/uart_dbg_ctrl.sv
// UART debug command controller.
// Decodes single-byte host commands from the UART receiver, sequences the
// processor under debug (run / single step / reset) and streams a fixed-size
// dump back through the transmitter, one byte per transmitter completion.
// Ports:
//   clock  : board clock, all state on rising edge
//   reset  : asynchronous active-high reset
//   bus    : controller side of uart_dbg_ctrl_if (see interface header)
// Parameters:
//   DUMP_BYTES : bytes per dump (>= 1)
//   ADDR_W     : dump_addr width (2**ADDR_W >= DUMP_BYTES), must match bus
module uart_dbg_ctrl
  import uart_dbg_pkg::*;
#(
  parameter int DUMP_BYTES = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  uart_dbg_ctrl_if.master        bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DUMP_BYTES - 1);

  state_t            state, state_nxt;
  logic              tx_start_q, tx_start_nxt;
  logic [7:0]        tx_data_q, tx_data_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              cpu_en_q, cpu_en_nxt;
  logic              cpu_rst_q, cpu_rst_nxt;
  // 'C' spends one extra cycle in IDLE with cpu_reset high before ACK starts.
  logic              clr_pend_q, clr_pend_nxt;
  logic              rx_evt, tx_evt;

  rise_detect u_rx_rise (
    .clock (clock),
    .reset (reset),
    .level (bus.rx_done),
    .pulse (rx_evt)
  );

  rise_detect u_tx_rise (
    .clock (clock),
    .reset (reset),
    .level (bus.tx_done),
    .pulse (tx_evt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      addr_q     <= '0;
      cpu_en_q   <= 1'b0;
      cpu_rst_q  <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      tx_start_q <= tx_start_nxt;
      tx_data_q  <= tx_data_nxt;
      addr_q     <= addr_nxt;
      cpu_en_q   <= cpu_en_nxt;
      cpu_rst_q  <= cpu_rst_nxt;
      clr_pend_q <= clr_pend_nxt;
    end
  end

  // tx_start is registered and raised on every transition into DUMP_LOAD or
  // ACK, so it is high in exactly the first cycle of those states.
  always_comb begin
    state_nxt    = state;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data_q;
    addr_nxt     = addr_q;
    cpu_en_nxt   = cpu_en_q;
    cpu_rst_nxt  = 1'b0;
    clr_pend_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (clr_pend_q) begin
          state_nxt    = ACK;
          tx_start_nxt = 1'b1;
          tx_data_nxt  = ACK_OK;
        end else if (rx_evt) begin
          case (bus.rx_data)
            CMD_RUN: begin
              state_nxt  = RUN;
              cpu_en_nxt = 1'b1;
            end
            CMD_STEP: begin
              state_nxt  = STEP;
              cpu_en_nxt = 1'b1;
            end
            CMD_DUMP: begin
              state_nxt    = DUMP_LOAD;
              addr_nxt     = '0;
              tx_start_nxt = 1'b1;
            end
            CMD_CLR: begin
              cpu_rst_nxt  = 1'b1;
              clr_pend_nxt = 1'b1;
            end
            default: begin
              state_nxt    = ACK;
              tx_start_nxt = 1'b1;
              tx_data_nxt  = ACK_ERR;
            end
          endcase
        end
      end

      RUN: begin
        // halted and an 'H' in the same cycle collapse into one transition
        if (bus.halted || (rx_evt && (bus.rx_data == CMD_HALT))) begin
          state_nxt    = DUMP_LOAD;
          cpu_en_nxt   = 1'b0;
          addr_nxt     = '0;
          tx_start_nxt = 1'b1;
        end
      end

      STEP: begin
        state_nxt    = DUMP_LOAD;
        cpu_en_nxt   = 1'b0;
        addr_nxt     = '0;
        tx_start_nxt = 1'b1;
      end

      DUMP_LOAD: begin
        // Capture the byte so tx_data stays stable through DUMP_WAIT.
        tx_data_nxt = bus.dump_data;
        state_nxt   = DUMP_WAIT;
      end

      DUMP_WAIT: begin
        if (tx_evt) begin
          if (addr_q == LAST_ADDR) begin
            state_nxt = IDLE;
            addr_nxt  = '0;
          end else begin
            state_nxt    = DUMP_LOAD;
            addr_nxt     = addr_q + ADDR_W'(1);
            tx_start_nxt = 1'b1;
          end
        end
      end

      ACK: begin
        if (tx_evt) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // In DUMP_LOAD the addressed byte is passed straight through so tx_data is
  // valid in the same cycle as tx_start; afterwards the captured copy holds it.
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = (state == DUMP_LOAD) ? bus.dump_data : tx_data_q;
  assign bus.dump_addr  = addr_q;
  assign bus.cpu_enable = cpu_en_q;
  assign bus.cpu_reset  = cpu_rst_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_dbg_ctrl.sv
module tb_uart_dbg_ctrl;

  logic clock;
  logic reset;
  int   tests;
  int   fails;
  int   pulse_cnt;
  int   en_cnt;
  int   rst_cnt;
  int   p0;
  int   e0;
  int   r0;

  uart_dbg_ctrl_if #(.ADDR_W(4)) bus ();

  uart_dbg_ctrl #(
    .DUMP_BYTES (16),
    .ADDR_W     (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  // Dump memory model: byte at addr is addr + 0xA0
  assign bus.dump_data = 8'hA0 + 8'(bus.dump_addr);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge bus.tx_start) pulse_cnt++;
  always @(posedge bus.cpu_reset) rst_cnt++;
  always @(negedge clock) if (bus.cpu_enable === 1'b1) en_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    tick(1);
    bus.rx_done = 1'b0;
  endtask

  task automatic wait_tx_start(input string tag);
    int n;
    n = 0;
    while (bus.tx_start !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    check(tag, 32'(bus.tx_start), 32'd1);
  endtask

  // Serve n dump bytes, answering each tx_start with a tx_done pulse 10 cycles later.
  task automatic run_dump(input int n);
    for (int i = 0; i < n; i++) begin
      wait_tx_start("dump_tx_start");
      check("dump_tx_data", 32'(bus.tx_data), 32'(8'hA0 + i));
      check("dump_addr", 32'(bus.dump_addr), 32'(i));
      tick(1);
      check("tx_start_width", 32'(bus.tx_start), 32'd0);
      check("tx_data_hold", 32'(bus.tx_data), 32'(8'hA0 + i));
      tick(9);
      bus.tx_done = 1'b1;
      tick(1);
      bus.tx_done = 1'b0;
      if (i < 15) begin
        check("next_tx_start_latency", 32'(bus.tx_start), 32'd1);
      end else begin
        check("dump_end_busy", 32'(bus.busy), 32'd0);
        check("dump_end_addr", 32'(bus.dump_addr), 32'd0);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    pulse_cnt = 0;
    en_cnt = 0;
    rst_cnt = 0;
    reset = 1'b1;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    bus.tx_done = 1'b0;
    bus.halted  = 1'b0;

    // Reset state
    tick(2);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h00);
    check("rst_dump_addr", 32'(bus.dump_addr), 32'd0);
    check("rst_cpu_enable", 32'(bus.cpu_enable), 32'd0);
    check("rst_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    tick(2);

    // tx event in IDLE is ignored
    p0 = pulse_cnt;
    bus.tx_done = 1'b1;
    tick(1);
    bus.tx_done = 1'b0;
    tick(2);
    check("idle_tx_evt_busy", 32'(bus.busy), 32'd0);
    check("idle_tx_evt_pulses", 32'(pulse_cnt - p0), 32'd0);

    // Unknown byte 'Z' with rx_done held 20 cycles: single ACK 0x3F, no CPU activity
    p0 = pulse_cnt;
    e0 = en_cnt;
    r0 = rst_cnt;
    bus.rx_data = 8'h5A;
    bus.rx_done = 1'b1;
    tick(1);
    check("z_tx_start", 32'(bus.tx_start), 32'd1);
    check("z_tx_data", 32'(bus.tx_data), 32'h3F);
    check("z_busy", 32'(bus.busy), 32'd1);
    tick(3);
    bus.tx_done = 1'b1;
    tick(1);
    bus.tx_done = 1'b0;
    check("z_ack_done_busy", 32'(bus.busy), 32'd0);
    tick(15);
    check("z_hold_busy", 32'(bus.busy), 32'd0);
    check("z_hold_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("z_no_cpu_enable", 32'(en_cnt - e0), 32'd0);
    check("z_no_cpu_reset", 32'(rst_cnt - r0), 32'd0);
    bus.rx_done = 1'b0;
    tick(2);

    // 'C': cpu_reset for one cycle, then ACK with 0x4B
    r0 = rst_cnt;
    send_byte(8'h43);
    check("c_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("c_no_tx_start_yet", 32'(bus.tx_start), 32'd0);
    tick(1);
    check("c_cpu_reset_drop", 32'(bus.cpu_reset), 32'd0);
    check("c_tx_start", 32'(bus.tx_start), 32'd1);
    check("c_tx_data", 32'(bus.tx_data), 32'h4B);
    check("c_busy", 32'(bus.busy), 32'd1);
    tick(4);
    check("c_ack_waits", 32'(bus.busy), 32'd1);
    bus.tx_done = 1'b1;
    tick(1);
    bus.tx_done = 1'b0;
    check("c_done_busy", 32'(bus.busy), 32'd0);
    check("c_reset_pulses", 32'(rst_cnt - r0), 32'd1);
    tick(2);

    // 'D': full 16-byte dump 0xA0..0xAF
    p0 = pulse_cnt;
    send_byte(8'h44);
    check("d_busy", 32'(bus.busy), 32'd1);
    run_dump(16);
    check("d_pulses", 32'(pulse_cnt - p0), 32'd16);
    tick(3);

    // 'R', repeated 'R' ignored, halted after 50 enabled cycles
    p0 = pulse_cnt;
    e0 = en_cnt;
    send_byte(8'h52);
    check("r_cpu_enable", 32'(bus.cpu_enable), 32'd1);
    check("r_busy", 32'(bus.busy), 32'd1);
    tick(10);
    send_byte(8'h52);
    check("r_repeat_enable", 32'(bus.cpu_enable), 32'd1);
    check("r_repeat_no_tx", 32'(pulse_cnt - p0), 32'd0);
    tick(38);
    bus.halted = 1'b1;
    tick(1);
    bus.halted = 1'b0;
    check("r_halt_enable_low", 32'(bus.cpu_enable), 32'd0);
    check("r_halt_tx_start", 32'(bus.tx_start), 32'd1);
    run_dump(16);
    check("r_enable_cycles", 32'(en_cnt - e0), 32'd50);
    check("r_pulses", 32'(pulse_cnt - p0), 32'd16);
    tick(3);

    // 'S' with rx_done held 20 cycles: one enabled cycle, one dump
    p0 = pulse_cnt;
    e0 = en_cnt;
    bus.rx_data = 8'h53;
    bus.rx_done = 1'b1;
    tick(1);
    check("s_cpu_enable", 32'(bus.cpu_enable), 32'd1);
    tick(1);
    check("s_cpu_enable_drop", 32'(bus.cpu_enable), 32'd0);
    check("s_tx_start", 32'(bus.tx_start), 32'd1);
    fork
      begin
        tick(18);
        bus.rx_done = 1'b0;
      end
    join_none
    run_dump(16);
    tick(5);
    check("s_enable_cycles", 32'(en_cnt - e0), 32'd1);
    check("s_pulses", 32'(pulse_cnt - p0), 32'd16);
    check("s_idle_after", 32'(bus.busy), 32'd0);

    // 'H' and halted together in RUN: one transition, one dump
    p0 = pulse_cnt;
    send_byte(8'h52);
    tick(4);
    bus.halted  = 1'b1;
    bus.rx_data = 8'h48;
    bus.rx_done = 1'b1;
    tick(1);
    bus.halted  = 1'b0;
    bus.rx_done = 1'b0;
    check("hh_tx_start", 32'(bus.tx_start), 32'd1);
    check("hh_cpu_enable", 32'(bus.cpu_enable), 32'd0);
    run_dump(16);
    tick(20);
    check("hh_pulses", 32'(pulse_cnt - p0), 32'd16);
    check("hh_idle", 32'(bus.busy), 32'd0);

    // Reset in RUN drops cpu_enable without waiting for a clock edge
    send_byte(8'h52);
    tick(3);
    reset = 1'b1;
    #1;
    check("run_rst_cpu_enable", 32'(bus.cpu_enable), 32'd0);
    check("run_rst_busy", 32'(bus.busy), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(2);

    // Reset mid-dump at dump_addr=5, no tx_start until a new 'D'
    p0 = pulse_cnt;
    send_byte(8'h44);
    run_dump(5);
    check("mid_dump_addr", 32'(bus.dump_addr), 32'd5);
    check("mid_dump_data", 32'(bus.tx_data), 32'hA5);
    reset = 1'b1;
    #1;
    check("mid_rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("mid_rst_tx_data", 32'(bus.tx_data), 32'h00);
    check("mid_rst_dump_addr", 32'(bus.dump_addr), 32'd0);
    check("mid_rst_cpu_enable", 32'(bus.cpu_enable), 32'd0);
    check("mid_rst_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(2);
    bus.tx_done = 1'b1;
    tick(1);
    bus.tx_done = 1'b0;
    tick(30);
    check("post_rst_pulses", 32'(pulse_cnt - p0), 32'd6);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    p0 = pulse_cnt;
    send_byte(8'h44);
    check("restart_tx_data", 32'(bus.tx_data), 32'hA0);
    run_dump(16);
    check("restart_pulses", 32'(pulse_cnt - p0), 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_dbg_ctrl.md
# uart_dbg_ctrl

Command controller between the UART receiver/transmitter pair and the processor under debug. It detects completed bytes from the receiver and decodes single-byte commands. It then sequences the processor (run, single step, reset) and streams a fixed-size debug dump back through the transmitter one byte at a time. It is the only block that drives the transmitter and the processor's debug controls.

## Interface
Parameters:
- DUMP_BYTES, 16, number of bytes sent per dump (≥1)
- ADDR_W, 4, width of dump_addr (2**ADDR_W ≥ DUMP_BYTES)

Ports:
- clock  in  1  board clock; all state on rising edge
- reset  in  1  asynchronous, active-high; one clock domain only
- rx_done  in  1  receiver completion flag; level, may stay high several cycles
- rx_data  in  8  received byte; valid while rx_done high
- tx_done  in  1  transmitter completion flag; level
- halted  in  1  processor reached halt instruction
- dump_data  in  8  byte at dump_addr; combinational, same cycle
- tx_start  out  1  one-cycle pulse starting a transmission
- tx_data  out  8  byte to send; held stable from tx_start until the next tx_start
- dump_addr  out  ADDR_W  current dump byte index
- cpu_enable  out  1  processor clock enable
- cpu_reset  out  1  one-cycle processor reset pulse
- busy  out  1  high in every state except IDLE

## Operation
- Byte event: rising edge of rx_done, taken as rx_done & ~rx_done_q. tx event: tx_done & ~tx_done_q. Level-high flags never retrigger.
- Commands are accepted only in IDLE. Byte events in other states are dropped, except 'H' in RUN.
- IDLE:
  - 'R' (0x52) → RUN.
  - 'S' (0x53) → STEP.
  - 'D' (0x44) → DUMP_LOAD with dump_addr=0.
  - 'C' (0x43) → cpu_reset pulse, then ACK with byte 0x4B.
  - Any other byte → ACK with byte 0x3F.
- RUN: cpu_enable=1. halted=1 or byte event 'H' (0x48) → DUMP_LOAD with dump_addr=0 and cpu_enable=0 in the same edge. If both occur in one cycle, the result is the same single transition.
- STEP: cpu_enable=1 for exactly one cycle → DUMP_LOAD with dump_addr=0.
- DUMP_LOAD: tx_data←dump_data, tx_start=1 for one cycle → DUMP_WAIT.
- DUMP_WAIT: on tx event:
  - dump_addr==DUMP_BYTES-1 → IDLE with dump_addr←0.
  - otherwise dump_addr+1 → DUMP_LOAD.
- ACK: tx_data←ack byte, tx_start pulse; wait for tx event → IDLE.
- dump_addr increments unsigned within ADDR_W and never wraps past DUMP_BYTES-1.

## Timing
- Reset values:
  - tx_start=0, tx_data=0x00, dump_addr=0
  - cpu_enable=0, cpu_reset=0, busy=0
  - state IDLE, rx_done_q=0, tx_done_q=0
- Reset mid-operation aborts immediately: cpu_enable drops asynchronously and no further tx_start is issued. The dump restarts only on a new command.
- Command latency: byte event sampled at edge t → new state and its outputs registered at edge t+1. For 'R', cpu_enable is high from t+1.
- tx_start is high exactly one cycle, at the first cycle of DUMP_LOAD or ACK. tx_data is already valid in that cycle.
- A tx event seen in any state other than DUMP_WAIT or ACK is ignored.
- Dump of N bytes produces exactly N tx_start pulses. Each pulse after the first follows its tx event by 1 cycle.
- cpu_reset is high for one cycle, the cycle before ACK begins.

## Structure
- Shared package uart_dbg_pkg:
  - command codes 'R', 'S', 'D', 'C', 'H'
  - ack codes 0x4B, 0x3F
  - state enum IDLE, RUN, STEP, DUMP_LOAD, DUMP_WAIT, ACK
- Sub-module rise_detect (registered rising-edge detector with asynchronous reset), instantiated once for rx_done and once for tx_done.
- Everything else in one FSM module.

## Test plan
- Reset asserted mid-dump at dump_addr=5 → all outputs at reset values. After release, no tx_start until a new 'D'.
- 'D' with DUMP_BYTES=16, dump_data=addr+0xA0, tx_done pulsed 10 cycles after each tx_start → 16 tx_start pulses with tx_data 0xA0…0xAF, then busy=0.
- 'R', then halted=1 after 50 cycles → cpu_enable high exactly 50 cycles, then a dump starts. A repeated 'R' during the run is ignored.
- 'S' → cpu_enable high exactly 1 cycle, followed by the full dump. rx_done held high for 20 cycles produces only one command.
- 'C' → one cpu_reset pulse, then tx_data=0x4B. 'Z' → tx_data=0x3F, no CPU activity.
- In RUN, 'H' byte event and halted=1 in the same cycle → a single transition to DUMP_LOAD and one dump only.
